ethernet_tx_engine: RTL and testbench

- Frame transmit sequencer sitting directly upstream of the Ethernet MAC bus controller.
- Acts as a bus master on the controller's register/data port: address bit 0 = 0 selects the index (register-select) cycle, address bit 0 = 1 selects the data cycle.
- On a start pulse it:
  - waits for the DM9000 TX request bit to clear;
  - streams a frame of 16-bit words from a local frame buffer into the MAC's TX SRAM;
  - programs the frame length;
  - triggers transmission.
- Reports done/error to the CPU-visible register block.

---
 rtl/ethernet_tx_engine.sv | 213 +++++++++++++++++++++
 tb/tb_ethernet_tx_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_tx_engine.sv
// Frame transmit sequencer: polls TCR, streams the frame buffer into the
// MAC TX SRAM, programs the length and triggers transmission over the bus.
module ethernet_tx_engine #(
    parameter int MAX_LEN  = 1536,
    parameter int POLL_MAX = 1023,
    parameter int BUF_AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       frame_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              err_timeout,
    output logic              buf_rd,
    output logic [BUF_AW-1:0] buf_addr,
    input  logic [15:0]       buf_data,
    output logic [31:0]       m_address,
    output logic              m_write,
    output logic              m_read,
    output logic [31:0]       m_data_wr,
    input  logic [31:0]       m_data_rd,
    input  logic              m_done
);

    localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
    localparam logic [15:0] POLL_MAX_W = 16'(POLL_MAX);

    typedef enum logic [3:0] {
        IDLE,
        POLL_IDX,
        POLL_RD,
        MWCMD_IDX,
        FETCH,
        CAPTURE,
        DATA_WR,
        LEN_LO_IDX,
        LEN_LO_DAT,
        LEN_HI_IDX,
        LEN_HI_DAT,
        TRIG_IDX,
        TRIG_DAT
    } state_t;

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] poll_cnt;
    logic [15:0] word_cnt;
    logic [15:0] nwords;
    logic [15:0] wdata;
    logic        req;
    logic        fin;
    logic        bad_len;
    logic        op_state;
    logic        op_wr;
    logic        op_addr;
    logic [15:0] op_data;
    logic        unused_rd;

    assign req       = m_write | m_read;
    assign fin       = req & m_done;
    assign nwords    = 16'((17'(len_q) + 17'd1) >> 1);
    assign bad_len   = (frame_len == 16'h0) || (frame_len > MAX_LEN_W);
    assign unused_rd = ^m_data_rd[31:1];

    // Bus operation implied by each state; non-bus states leave op_state low.
    always_comb begin
        op_state = 1'b1;
        op_wr    = 1'b1;
        op_addr  = 1'b0;
        op_data  = 16'h0000;
        case (state)
            POLL_IDX:   op_data = 16'h0002;
            POLL_RD: begin
                op_wr   = 1'b0;
                op_addr = 1'b1;
            end
            MWCMD_IDX:  op_data = 16'h00F8;
            DATA_WR: begin
                op_addr = 1'b1;
                op_data = wdata;
            end
            LEN_LO_IDX: op_data = 16'h00FC;
            LEN_LO_DAT: begin
                op_addr = 1'b1;
                op_data = {8'h00, len_q[7:0]};
            end
            LEN_HI_IDX: op_data = 16'h00FD;
            LEN_HI_DAT: begin
                op_addr = 1'b1;
                op_data = {8'h00, len_q[15:8]};
            end
            TRIG_IDX:   op_data = 16'h0002;
            TRIG_DAT: begin
                op_addr = 1'b1;
                op_data = 16'h0001;
            end
            default:    op_state = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_timeout <= 1'b0;
            buf_rd      <= 1'b0;
            buf_addr    <= '0;
            m_address   <= 32'h0;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            m_data_wr   <= 32'h0;
            len_q       <= 16'h0;
            poll_cnt    <= 16'h0;
            word_cnt    <= 16'h0;
            wdata       <= 16'h0;
        end else begin
            done   <= 1'b0;
            error  <= 1'b0;
            buf_rd <= 1'b0;

            // A request rises one cycle after the state is entered, so the
            // request is always low for at least one cycle between ops.
            if (op_state && !req) begin
                m_write   <= op_wr;
                m_read    <= ~op_wr;
                m_address <= {31'h0, op_addr};
                m_data_wr <= {16'h0, op_data};
            end
            if (fin) begin
                m_write <= 1'b0;
                m_read  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= frame_len;
                        if (bad_len) begin
                            error <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            err_timeout <= 1'b0;
                            poll_cnt    <= 16'h0;
                            state       <= POLL_IDX;
                        end
                    end
                end
                POLL_IDX: if (fin) state <= POLL_RD;
                POLL_RD: begin
                    if (fin) begin
                        if (!m_data_rd[0]) begin
                            state <= MWCMD_IDX;
                        end else if (poll_cnt == POLL_MAX_W) begin
                            err_timeout <= 1'b1;
                            error       <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 16'd1;
                            state    <= POLL_IDX;
                        end
                    end
                end
                MWCMD_IDX: begin
                    if (fin) begin
                        word_cnt <= 16'h0;
                        buf_rd   <= 1'b1;
                        buf_addr <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH:   state <= CAPTURE;
                CAPTURE: begin
                    wdata <= buf_data;
                    state <= DATA_WR;
                end
                DATA_WR: begin
                    if (fin) begin
                        if (word_cnt + 16'd1 == nwords) begin
                            state <= LEN_LO_IDX;
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                            buf_rd   <= 1'b1;
                            buf_addr <= BUF_AW'(word_cnt + 16'd1);
                            state    <= FETCH;
                        end
                    end
                end
                LEN_LO_IDX: if (fin) state <= LEN_LO_DAT;
                LEN_LO_DAT: if (fin) state <= LEN_HI_IDX;
                LEN_HI_IDX: if (fin) state <= LEN_HI_DAT;
                LEN_HI_DAT: if (fin) state <= TRIG_IDX;
                TRIG_IDX:   if (fin) state <= TRIG_DAT;
                TRIG_DAT: begin
                    if (fin) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ethernet_tx_engine.sv
// Directed bench: expected bus-op list built from the frame rules, checked
// against every op the engine issues, with a simple bus slave and buffer.
module tb_ethernet_tx_engine;

    localparam int PM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic        busy, done, error, err_timeout, buf_rd;
    logic [9:0]  buf_addr;
    logic [15:0] buf_data;
    logic [31:0] m_address;
    logic        m_write, m_read;
    logic [31:0] m_data_wr;
    logic [31:0] m_data_rd;
    logic        m_done;

    always #5 clk = ~clk;

    ethernet_tx_engine #(
        .MAX_LEN(1536),
        .POLL_MAX(PM),
        .BUF_AW(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done), .error(error), .err_timeout(err_timeout),
        .buf_rd(buf_rd), .buf_addr(buf_addr), .buf_data(buf_data),
        .m_address(m_address), .m_write(m_write), .m_read(m_read),
        .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_done(m_done)
    );

    typedef struct packed {
        logic        wr;
        logic        addr;
        logic [15:0] data;
    } op_t;

    op_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ops_seen = 0;
    int  tcr_ones = 0;
    int  reads_seen = 0;
    bit  spur_en = 0;

    function automatic logic [15:0] buf_word(int i);
        return 16'(i) ^ 16'hA5C3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Synchronous frame buffer: data valid the cycle after buf_rd.
    always @(posedge clk) begin
        if (buf_rd) buf_data <= buf_word(int'(buf_addr));
    end

    // Bus slave with varying latency and optional stray m_done pulses.
    initial begin
        int cnt = 0;
        int opn = 0;
        m_done = 1'b0;
        m_data_rd = 32'h0;
        forever begin
            @(negedge clk);
            if (m_done) begin
                m_done = 1'b0;
            end else if (rst || !(m_write || m_read)) begin
                cnt = 0;
                if (spur_en && !rst) m_done = 1'b1;
            end else begin
                cnt++;
                if (cnt >= 1 + opn % 3) begin
                    m_done = 1'b1;
                    cnt = 0;
                    opn++;
                    if (m_read) begin
                        m_data_rd = {16'hDEAD,
                                     16'h0100 | 16'(reads_seen < tcr_ones)};
                        reads_seen++;
                    end
                end
            end
        end
    end

    // Compare every issued op against the expected list.
    initial begin
        op_t cur, held, e;
        bit  prev = 0;
        forever begin
            @(negedge clk);
            if (m_write || m_read) begin
                cur = '{m_write, m_address[0], m_data_wr[15:0]};
                if (!prev) begin
                    ops_seen++;
                    check("req_onehot", 32'(m_write ^ m_read), 1);
                    check("addr_hi_zero", 32'(m_address[31:1]), 0);
                    check("wdata_hi_zero", 32'(m_data_wr[31:16]), 0);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_op: got wr=%0d a=%0d d=%h, required none",
                                 cur.wr, cur.addr, cur.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("op_kind", 32'({cur.wr, cur.addr}),
                              32'({e.wr, e.addr}));
                        if (e.wr) check("op_data", 32'(cur.data), 32'(e.data));
                    end
                    held = cur;
                end else begin
                    check("op_stable", 32'(cur), 32'(held));
                end
            end
            prev = m_write || m_read;
        end
    end

    function automatic void push(bit wr, bit a, logic [15:0] d);
        exp_q.push_back(op_t'{wr, a, d});
    endfunction

    task automatic build(int len, int ones, bit tmo);
        int polls;
        polls = tmo ? PM + 1 : ones + 1;
        exp_q.delete();
        for (int p = 0; p < polls; p++) begin
            push(1, 0, 16'h0002);
            push(0, 1, 16'h0000);
        end
        if (!tmo) begin
            push(1, 0, 16'h00F8);
            for (int w = 0; w < (len + 1) / 2; w++) push(1, 1, buf_word(w));
            push(1, 0, 16'h00FC);
            push(1, 1, 16'(len % 256));
            push(1, 0, 16'h00FD);
            push(1, 1, 16'(len / 256));
            push(1, 0, 16'h0002);
            push(1, 1, 16'h0001);
        end
    endtask

    task automatic run_frame(string tag, int len, int ones, bit tmo,
                             int exp_ops, bit poke);
        bit fin = 0;
        build(len, ones, tmo);
        tcr_ones = ones;
        reads_seen = 0;
        ops_seen = 0;
        @(negedge clk);
        start = 1'b1;
        frame_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_errtmo_clr"}, 32'(err_timeout), 0);
        for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done || error) begin
                fin = 1;
                check({tag, "_done"}, 32'(done), 32'(!tmo));
                check({tag, "_error"}, 32'(error), 32'(tmo));
                check({tag, "_errtmo"}, 32'(err_timeout), 32'(tmo));
            end
            check({tag, "_busy"}, 32'(busy), 32'(!fin));
            if (poke && cyc == 20) begin
                start = 1'b1;
                frame_len = 16'h0;
            end else begin
                start = 1'b0;
            end
        end
        if (!fin) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_finish: got no done/error, required one", tag);
        end
        @(negedge clk);
        check({tag, "_pulse_len"}, 32'({done, error}), 0);
        check({tag, "_ops"}, ops_seen, exp_ops);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    task automatic bad_len(string tag, int len);
        exp_q.delete();
        ops_seen = 0;
        @(negedge clk);
        start = 1'b1;
        frame_len = 16'(len);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_error"}, 32'(error), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        repeat (5) begin
            @(negedge clk);
            check({tag, "_quiet"}, 32'({busy, error, m_write, m_read}), 0);
        end
        check({tag, "_ops"}, ops_seen, 0);
    endtask

    initial begin
        int  dw = 0;
        bit  hit = 0;
        bit  pw = 0;
        rst = 1'b1;
        start = 1'b0;
        frame_len = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 32'({busy, done, error, err_timeout, buf_rd,
                              m_write, m_read}), 0);
        check("rst_buf_addr", 32'(buf_addr), 0);
        check("rst_m_address", m_address, 0);
        check("rst_m_data_wr", m_data_wr, 0);
        rst = 1'b0;

        run_frame("len64", 64, 0, 0, 41, 1);

        build(61, 0, 0);
        check("model61_size", exp_q.size(), 40);
        check("model61_lo", 32'(exp_q[35].data), 32'h3D);
        check("model61_hi", 32'(exp_q[37].data), 32'h00);
        spur_en = 1;
        run_frame("len61", 61, 0, 0, 40, 0);
        spur_en = 0;

        run_frame("poll4", 4, 3, 0, 17, 0);
        run_frame("tmo", 64, 1000, 1, 8, 0);
        run_frame("after_tmo", 2, 0, 0, 10, 0);
        run_frame("len1", 1, 0, 0, 10, 0);
        run_frame("len1536", 1536, 0, 0, 777, 0);
        bad_len("len0", 0);
        bad_len("len1537", 1537);

        build(64, 0, 0);
        tcr_ones = 0;
        reads_seen = 0;
        @(negedge clk);
        start = 1'b1;
        frame_len = 16'd64;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            @(negedge clk);
            if (m_write && m_address[0] && !pw) dw++;
            pw = m_write;
            if (dw == 11) begin
                hit = 1;
                rst = 1'b1;
            end
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL rst_mid_reach: got %0d data writes, required 11", dw);
        end
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ctl", 32'({busy, done, error, buf_rd, m_write, m_read}), 0);
        check("rst_mid_addr", m_address, 0);
        check("rst_mid_data", m_data_wr, 0);
        check("rst_mid_buf_addr", 32'(buf_addr), 0);
        run_frame("post_rst", 2, 0, 0, 10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
